dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache that sits between the CPU data path and the data port (port 2) of the unified instruction/data memory. It is the initiator for that port's protocol: the CPU issues single-word loads and stores, and the block fills 4-word lines and forwards stores by driving `readM2`, `writeM2`, `address2` and the bidirectional `data2` bus. Hit and miss counters are exposed for performance measurement.

## Interface
- `LINES`, default 4: number of cache lines (power of two, ≥2).
- `WORDS`, default 4: words per line; fixed at 4, so the offset is 2 bits.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_read` in 1: load request; held until `cpu_ready`.
- `cpu_write` in 1: store request; held until `cpu_ready`.
- `cpu_address` in 16: word address.
- `cpu_wdata` in 16: store data.
- `cpu_rdata` out 16: load data; valid when `cpu_ready`=1 on a read.
- `cpu_ready` out 1: request completes this cycle.
- `readM2` out 1: memory port-2 read enable.
- `writeM2` out 1: memory port-2 write enable.
- `address2` out 16: memory port-2 address.
- `data2` inout 16: driven with the store data only while `writeM2`=1, otherwise high-Z.
- `hit_count` out 16: saturating count of read hits.
- `miss_count` out 16: saturating count of read misses.

## Operation
- Address split: `offset`=addr[1:0], `index`=addr[2+log2(LINES)-1:2], `tag`=remaining upper bits. Per line: valid bit, tag, and 4×16-bit data words.
- States: IDLE, FILL, WRITE.
- **IDLE, read hit:** `cpu_ready`=1 combinationally, `cpu_rdata`=line word[offset], `hit_count`+1. Stay in IDLE.
- **IDLE, read miss:** `miss_count`+1, go to FILL, latch the line base (addr & ~3), and clear the fill counter.
- **FILL:** 5 cycles, k=0..4. `readM2`=1 for all five. `address2`=base+min(k,3). In cycles k=1..4, capture `data2` into word k-1. At the end of k=4, set valid, write the tag, and return to IDLE. The held request now hits and completes there. That hit is not counted: a miss is counted once only.
- **IDLE, write:** go to WRITE. `cpu_write` wins if `cpu_read` is also asserted.
- **WRITE:** one cycle. `writeM2`=1, `address2`=`cpu_address`, `data2`=`cpu_wdata`, `cpu_ready`=1. On a hit, update the cached word at the same edge; on a miss, leave the cache unchanged. Return to IDLE.
- `readM2` and `writeM2` are never asserted together. `data2` is never driven while `readM2`=1.
- Counters saturate at 16'hFFFF.
- In IDLE with no request: `readM2`=`writeM2`=0, `address2` holds its last value.

## Timing
- Reset value of every output while `reset_n`=0 (asynchronous): `cpu_ready`=0, `cpu_rdata`=0, `readM2`=0, `writeM2`=0, `address2`=0, `data2`=Z, `hit_count`=0, `miss_count`=0. State goes to IDLE and all valid bits clear.
- Reset asserted mid-FILL or mid-WRITE: abort immediately. The partial line stays invalid.
- Read hit latency: 0 cycles (same cycle as the request).
- Read miss latency: 6 cycles (5 FILL + 1 IDLE hit).
- Store latency: 1 cycle after the request is seen in IDLE.
- Memory model contract: data for the address presented at edge N appears on `data2` during cycle N+1 while `readM2` stays high.
- The CPU must hold its address and data stable until `cpu_ready`.

## Structure
- Shared package `cache_pkg`: `WORD_SIZE`=16, the offset width, the state encoding (IDLE/FILL/WRITE), and the counter width.
- One natural sub-module: `sat_counter` (16-bit, enable, async active-low clear), instantiated for the hit and miss counters.
- Tag/valid/data arrays live in flops inside `dcache_ctrl`. No SRAM macro is used.

## Test plan
- **Reset, then cold read:** read 16'h0023 with memory[0x20..0x23]=0,0,0,6000. Expect the FILL addresses 20,21,22,23,23, then `cpu_ready` with `cpu_rdata`=16'h6000 on cycle 6, and `miss_count`=1.
- **Hit after fill:** read 16'h0021. Expect `cpu_ready` in the same cycle, `cpu_rdata`=0, `hit_count`=1, and no `readM2` pulse.
- **Write hit:** write 16'h0021 with 16'hBEEF. Expect one cycle with `writeM2`=1, `address2`=21, `data2`=BEEF. A subsequent read of 21 hits and returns BEEF.
- **Write miss:** write 16'h0045 with 16'h1234. Expect the memory write and no allocation. A subsequent read of 45 misses and fills 44..47, returning 1234.
- **Conflict eviction:** with LINES=4, read 0x20, then 0x30 (same index), then 0x20. Expect three misses.
- **Reset mid-FILL:** drop `reset_n` at FILL k=2. Expect `readM2`=0 immediately. After release, re-reading the same address misses again and the counters read 0 before the re-read.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the data cache: word size, offset width, counter
// width and the controller state encoding.
package cache_pkg;

  localparam int WORD_SIZE = 16;
  localparam int OFFSET_W  = 2;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  // Word address of the first word of the line containing addr.
  function automatic logic [WORD_SIZE-1:0] line_base(input logic [WORD_SIZE-1:0] addr);
    return {addr[WORD_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side load/store handshake of the data cache.
interface dcache_ctrl_if;
  import cache_pkg::*;

  logic                 cpu_read;
  logic                 cpu_write;
  logic [WORD_SIZE-1:0] cpu_address;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic [WORD_SIZE-1:0] cpu_rdata;
  logic                 cpu_ready;

  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_wdata,
    input  cpu_rdata, cpu_ready
  );

  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_wdata,
    output cpu_rdata, cpu_ready
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count up on enable, hold at the maximum value.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= {CNT_W{1'b0}};
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of
// memory port 2, with saturating read hit/miss counters.
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int LINES = 4,
  parameter int WORDS = 4
)(
  input  logic                 clk,
  input  logic                 reset_n,
  dcache_ctrl_if.slave         cpu,
  output logic                 readM2,
  output logic                 writeM2,
  output logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WORD_SIZE - OFFSET_W - IDX_W;

  state_e                 state_r, state_s;
  logic [2:0]             fill_k_r;
  logic [WORD_SIZE-1:0]   base_r;
  logic [WORD_SIZE-1:0]   last_addr_r;
  logic                   fill_done_r;

  logic                   valid_r [LINES];
  logic [TAG_W-1:0]       tag_r   [LINES];
  logic [WORD_SIZE-1:0]   data_r  [LINES][WORDS];

  logic [IDX_W-1:0]       idx_s;
  logic [TAG_W-1:0]       tag_s;
  logic [OFFSET_W-1:0]    off_s;
  logic                   hit_s;
  logic [IDX_W-1:0]       fill_idx_s;
  logic [TAG_W-1:0]       fill_tag_s;
  logic [OFFSET_W-1:0]    fill_word_s;
  logic [OFFSET_W-1:0]    fill_off_s;
  logic                   fill_last_s;

  logic                   ready_s;
  logic [WORD_SIZE-1:0]   rdata_s;
  logic [WORD_SIZE-1:0]   addr_s;
  logic                   hit_en_s;
  logic                   miss_en_s;

  assign idx_s       = cpu.cpu_address[OFFSET_W +: IDX_W];
  assign tag_s       = cpu.cpu_address[WORD_SIZE-1 -: TAG_W];
  assign off_s       = cpu.cpu_address[OFFSET_W-1:0];
  assign hit_s       = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign fill_idx_s  = base_r[OFFSET_W +: IDX_W];
  assign fill_tag_s  = base_r[WORD_SIZE-1 -: TAG_W];
  assign fill_last_s = (fill_k_r == 3'(WORDS));
  // Data returned in cycle k belongs to the address presented in cycle k-1.
  assign fill_word_s = OFFSET_W'(fill_k_r - 3'd1);
  assign fill_off_s  = (fill_k_r >= 3'(WORDS-1)) ? OFFSET_W'(WORDS-1) : fill_k_r[OFFSET_W-1:0];

  assign cpu.cpu_ready = ready_s;
  assign cpu.cpu_rdata = rdata_s;
  assign address2      = addr_s;
  assign data2         = writeM2 ? cpu.cpu_wdata : {WORD_SIZE{1'bz}};

  // Next-state and bus/handshake outputs.
  always_comb begin
    state_s   = state_r;
    ready_s   = 1'b0;
    rdata_s   = {WORD_SIZE{1'b0}};
    readM2    = 1'b0;
    writeM2   = 1'b0;
    addr_s    = last_addr_r;
    hit_en_s  = 1'b0;
    miss_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu.cpu_write) begin
          state_s = WRITE;
        end else if (cpu.cpu_read) begin
          if (hit_s) begin
            ready_s  = 1'b1;
            rdata_s  = data_r[idx_s][off_s];
            // The completion right after a fill was already counted as a miss.
            hit_en_s = !fill_done_r;
          end else begin
            miss_en_s = 1'b1;
            state_s   = FILL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        readM2 = 1'b1;
        addr_s = base_r + {{(WORD_SIZE-OFFSET_W){1'b0}}, fill_off_s};
        if (fill_last_s) begin
          state_s = IDLE;
        end else begin
          state_s = FILL;
        end
      end
      WRITE: begin
        writeM2 = 1'b1;
        addr_s  = cpu.cpu_address;
        ready_s = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Controller state, fill sequencing and held bus address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      fill_k_r    <= 3'd0;
      base_r      <= {WORD_SIZE{1'b0}};
      last_addr_r <= {WORD_SIZE{1'b0}};
      fill_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      last_addr_r <= addr_s;
      fill_done_r <= (state_r == FILL) && fill_last_s;
      if (miss_en_s) begin
        base_r   <= line_base(cpu.cpu_address);
        fill_k_r <= 3'd0;
      end else if (state_r == FILL) begin
        fill_k_r <= fill_k_r + 3'd1;
      end else begin
        fill_k_r <= fill_k_r;
      end
    end
  end

  // Tag, valid and data arrays: filled from memory, patched by write hits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int l = 0; l < LINES; l++) begin
        valid_r[l] <= 1'b0;
        tag_r[l]   <= {TAG_W{1'b0}};
        for (int w = 0; w < WORDS; w++) begin
          data_r[l][w] <= {WORD_SIZE{1'b0}};
        end
      end
    end else begin
      if ((state_r == FILL) && (fill_k_r != 3'd0)) begin
        data_r[fill_idx_s][fill_word_s] <= data2;
      end
      if ((state_r == FILL) && fill_last_s) begin
        valid_r[fill_idx_s] <= 1'b1;
        tag_r[fill_idx_s]   <= fill_tag_s;
      end
      if ((state_r == WRITE) && hit_s) begin
        data_r[idx_s][off_s] <= cpu.cpu_wdata;
      end
    end
  end

  sat_counter u_hit_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .en    (hit_en_s),
    .count (hit_count)
  );

  sat_counter u_miss_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .en    (miss_en_s),
    .count (miss_count)
  );

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomised self-checking bench for dcache_ctrl against a line-level
// reference model and a behavioural port-2 memory.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        readM2, writeM2;
  logic [15:0] address2;
  wire  [15:0] data2;
  logic [15:0] hit_count, miss_count;

  dcache_ctrl_if cpu_if ();

  dcache_ctrl #(.LINES(4), .WORDS(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu        (cpu_if),
    .readM2     (readM2),
    .writeM2    (writeM2),
    .address2   (address2),
    .data2      (data2),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // Memory device: one-cycle read latency on port 2.
  function automatic logic [15:0] init_word(input int i);
    if (i >= 32 && i <= 34) return 16'h0000;
    if (i == 35) return 16'h6000;
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  logic [15:0] mem [256];
  logic [15:0] mem_q = 16'h0000;
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      if (readM2)  mem_q <= mem[address2[7:0]];
      if (writeM2) mem[address2[7:0]] <= data2;
    end
  end

  assign data2 = readM2 ? mem_q : 16'bz;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) check("rd_wr_excl", {31'd0, readM2 & writeM2}, 32'd0);
  end

  // Reference model: per-line valid/tag, memory image and counter totals.
  logic        mv [4];
  logic [11:0] mt [4];
  logic [15:0] mref [256];
  int          mhit, mmiss;

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      mt[i] = 12'h000;
    end
    mhit  = 0;
    mmiss = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, cpu_if.cpu_ready}, 32'd0);
    check({tag, "_rdata"}, {16'd0, cpu_if.cpu_rdata}, 32'd0);
    check({tag, "_readM2"}, {31'd0, readM2}, 32'd0);
    check({tag, "_writeM2"}, {31'd0, writeM2}, 32'd0);
    check({tag, "_addr2"}, {16'd0, address2}, 32'd0);
    check({tag, "_hits"}, {16'd0, hit_count}, 32'd0);
    check({tag, "_misses"}, {16'd0, miss_count}, 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    cpu_if.cpu_read = 1'b0;
    cpu_if.cpu_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // One CPU transaction, checked against the model. Called at posedge+1.
  task automatic do_req(input logic wr, input logic rd, input logic [15:0] a,
                        input logic [15:0] d, output logic [15:0] rdata);
    logic [1:0]  idx;
    logic [11:0] tg;
    logic        hit, got;
    int          lat, exp_lat, exp_fills;
    logic [15:0] fills [$];
    idx = a[3:2];
    tg  = a[15:4];
    hit = mv[idx] && (mt[idx] == tg);
    exp_lat   = wr ? 1 : (hit ? 0 : 6);
    exp_fills = (!wr && !hit) ? 5 : 0;
    cpu_if.cpu_read    = rd;
    cpu_if.cpu_write   = wr;
    cpu_if.cpu_address = a;
    cpu_if.cpu_wdata   = d;
    lat = 0;
    got = 1'b0;
    rdata = 16'h0000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (readM2) fills.push_back(address2);
      if (cpu_if.cpu_ready) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    check("ready_seen", {31'd0, got}, 32'd1);
    check("latency", lat, exp_lat);
    if (got && wr) begin
      check("wr_strobe", {31'd0, writeM2}, 32'd1);
      check("wr_addr", {16'd0, address2}, {16'd0, a});
      check("wr_data", {16'd0, data2}, {16'd0, d});
    end else if (got) begin
      rdata = cpu_if.cpu_rdata;
      check("rd_data", {16'd0, cpu_if.cpu_rdata}, {16'd0, mref[a[7:0]]});
    end
    check("fill_cycles", fills.size(), exp_fills);
    if (fills.size() == exp_fills) begin
      for (int k = 0; k < exp_fills; k++)
        check("fill_addr", {16'd0, fills[k]}, {16'd0, a & 16'hFFFC} + ((k > 3) ? 3 : k));
    end
    @(posedge clk);
    #1;
    cpu_if.cpu_read  = 1'b0;
    cpu_if.cpu_write = 1'b0;
    if (wr) begin
      mref[a[7:0]] = d;
    end else if (hit) begin
      mhit = sat_inc(mhit);
    end else begin
      mmiss   = sat_inc(mmiss);
      mv[idx] = 1'b1;
      mt[idx] = tg;
    end
    check("hit_count", {16'd0, hit_count}, mhit);
    check("miss_count", {16'd0, miss_count}, mmiss);
  endtask

  logic [15:0] rd_v;
  int          k_seen;

  initial begin
    for (int i = 0; i < 256; i++) mref[i] = init_word(i);
    cpu_if.cpu_read    = 1'b0;
    cpu_if.cpu_write   = 1'b0;
    cpu_if.cpu_address = 16'h0000;
    cpu_if.cpu_wdata   = 16'h0000;
    reset_n = 1'b0;
    #2;
    check_reset_outputs("async_reset");
    apply_reset();

    // Cold read, hit after fill, write hit and write miss.
    do_req(1'b0, 1'b1, 16'h0023, 16'h0000, rd_v);
    check("cold_data", {16'd0, rd_v}, 32'h6000);
    check("cold_miss", {16'd0, miss_count}, 32'd1);
    do_req(1'b0, 1'b1, 16'h0021, 16'h0000, rd_v);
    check("hit_data", {16'd0, rd_v}, 32'h0000);
    check("hit_count1", {16'd0, hit_count}, 32'd1);
    do_req(1'b1, 1'b0, 16'h0021, 16'hBEEF, rd_v);
    do_req(1'b0, 1'b1, 16'h0021, 16'h0000, rd_v);
    check("wr_hit_data", {16'd0, rd_v}, 32'hBEEF);
    do_req(1'b1, 1'b0, 16'h0045, 16'h1234, rd_v);
    do_req(1'b0, 1'b1, 16'h0045, 16'h0000, rd_v);
    check("wr_miss_data", {16'd0, rd_v}, 32'h1234);

    // Conflict eviction on line 0.
    apply_reset();
    do_req(1'b0, 1'b1, 16'h0020, 16'h0000, rd_v);
    do_req(1'b0, 1'b1, 16'h0030, 16'h0000, rd_v);
    do_req(1'b0, 1'b1, 16'h0020, 16'h0000, rd_v);
    check("conflict_misses", {16'd0, miss_count}, 32'd3);
    check("conflict_hits", {16'd0, hit_count}, 32'd0);

    // Reset during the third fill cycle.
    cpu_if.cpu_read    = 1'b1;
    cpu_if.cpu_address = 16'h0024;
    k_seen = 0;
    for (int c = 0; c < 20 && k_seen < 3; c++) begin
      @(negedge clk);
      if (readM2) k_seen++;
    end
    check("midfill_reached", k_seen, 3);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midfill");
    cpu_if.cpu_read = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    check("pre_reread_hits", {16'd0, hit_count}, 32'd0);
    check("pre_reread_misses", {16'd0, miss_count}, 32'd0);
    do_req(1'b0, 1'b1, 16'h0024, 16'h0000, rd_v);
    check("reread_miss", {16'd0, miss_count}, 32'd1);

    // Random mix of loads, stores and simultaneous requests.
    for (int n = 0; n < 300; n++) begin
      logic        w, r;
      logic [15:0] a, d;
      w = ($urandom_range(0, 9) < 3);
      r = w ? ($urandom_range(0, 1) == 1) : 1'b1;
      a = 16'($urandom_range(0, 63));
      d = 16'($urandom);
      do_req(w, r, a, d, rd_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
